// File: rtl/counter_cmp_irq.sv
// counter_cmp_irq: compare/interrupt stage that sits behind the free-running
// user counter. Two compare channels with rising-edge match detection, a
// capture register on channel 0, a level interrupt and a simple PWM output.
// The register file uses the same valid/ready/wstrb native bus as the counter.
//
// Bus handshake (valid/ready):
//   The master raises valid with we/addr/wstrb/wdata stable and holds them
//   until it sees ready. The access is performed on the clock edge where the
//   FSM is IDLE and valid is high. Write side effects commit on that edge.
//   ready is high for exactly the following cycle, and rdata is valid only
//   during that cycle (0 otherwise). The ACK cycle ignores valid, so a master
//   that keeps valid high gets a new access every second cycle. An
//   asynchronous reset returns the FSM to IDLE without issuing ready.
//
// BITS must be 32: byte-lane strobes assume four 8-bit lanes.

module counter_cmp_irq #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_enb,
  input  logic [BITS-1:0] count,
  input  logic            valid,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [3:0]      wstrb,
  input  logic [BITS-1:0] wdata,
  output logic            ready,
  output logic [BITS-1:0] rdata,
  output logic            irq,
  output logic [1:0]      match,
  output logic            pwm_out
);

  // Register word indices.
  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_CMP0    = 3'd1;
  localparam logic [2:0] A_CMP1    = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_CAPTURE = 3'd4;

  // CTRL bit positions.
  localparam int C_EN0      = 0;
  localparam int C_EN1      = 1;
  localparam int C_IE0      = 2;
  localparam int C_IE1      = 3;
  localparam int C_PWM_EN   = 4;
  localparam int C_ONESHOT0 = 5;

  // Bus FSM state; state_q is the observable state for checkers.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

  bus_state_t state_q;
  bus_state_t state_d;

  // Architectural registers.
  logic [5:0]      ctrl_q;
  logic [5:0]      ctrl_d;
  logic [BITS-1:0] cmp0_q;
  logic [BITS-1:0] cmp0_d;
  logic [BITS-1:0] cmp1_q;
  logic [BITS-1:0] cmp1_d;
  logic [1:0]      status_q;
  logic [1:0]      status_d;
  logic [BITS-1:0] capture_q;
  logic [BITS-1:0] rdata_q;
  logic [BITS-1:0] rd_mux;

  // Match detection state.
  logic [1:0] eq;
  logic [1:0] eq_prev_q;
  logic [1:0] hit;
  logic [1:0] match_q;
  logic       irq_q;
  logic       pwm_q;

  // Decoded bus strobes.
  logic       access;
  logic       wr_en;
  logic       wr_ctrl;
  logic       wr_cmp0;
  logic       wr_cmp1;
  logic       wr_status;
  logic [1:0] w1c_mask;

  // Merge the write data into an existing word, one byte lane per strobe bit.
  function automatic logic [BITS-1:0] merge_bytes(
    input logic [BITS-1:0] old_v,
    input logic [BITS-1:0] new_v,
    input logic [3:0]      strb
  );
    logic [BITS-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        r[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return r;
  endfunction

  // ------------------------------------------------------------------------
  // Bus FSM
  // ------------------------------------------------------------------------

  // State register: IDLE after reset, no pending acknowledge survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept a request in IDLE, always return from ACK after one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready is the ACK state itself, so it lasts exactly one cycle.
  always_comb begin
    ready = (state_q == ST_ACK);
  end

  assign access    = (state_q == ST_IDLE) && valid;
  assign wr_en     = access && we;
  assign wr_ctrl   = wr_en && (addr == A_CTRL);
  assign wr_cmp0   = wr_en && (addr == A_CMP0);
  assign wr_cmp1   = wr_en && (addr == A_CMP1);
  assign wr_status = wr_en && (addr == A_STATUS);
  assign w1c_mask  = (wr_status && wstrb[0]) ? wdata[1:0] : 2'b00;

  // Read multiplexer over the current register contents; unmapped words read 0.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:    rd_mux = {{(BITS-6){1'b0}}, ctrl_q};
      A_CMP0:    rd_mux = cmp0_q;
      A_CMP1:    rd_mux = cmp1_q;
      A_STATUS:  rd_mux = {{(BITS-2){1'b0}}, status_q};
      A_CAPTURE: rd_mux = capture_q;
      default:   rd_mux = '0;
    endcase
  end

  // Read data is registered on the accepting edge and zero outside ACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (access && !we) begin
      rdata_q <= rd_mux;
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

  // ------------------------------------------------------------------------
  // Match detection
  // ------------------------------------------------------------------------

  // Per-channel equality, qualified by the channel enable.
  always_comb begin
    eq[0] = ctrl_q[C_EN0] && (count == cmp0_q);
    eq[1] = ctrl_q[C_EN1] && (count == cmp1_q);
  end

  // A hit is a rising edge of eq seen on an enabled counter cycle.
  always_comb begin
    hit = clk_enb ? (eq & ~eq_prev_q) : 2'b00;
  end

  // Previous-equality flags advance only with the counter enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eq_prev_q <= 2'b00;
    end else if (clk_enb) begin
      eq_prev_q <= eq;
    end
  end

  // One-cycle match pulses, one cycle after the hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 2'b00;
    end else begin
      match_q <= hit;
    end
  end

  assign match = match_q;

  // ------------------------------------------------------------------------
  // Register file
  // ------------------------------------------------------------------------

  // Next register values: hardware updates first, software writes layered on top
  // for CTRL (software wins), hardware set layered on top for STATUS (set wins).
  always_comb begin
    ctrl_d = ctrl_q;
    if (hit[0] && ctrl_q[C_ONESHOT0]) begin
      ctrl_d[C_EN0] = 1'b0;
    end
    if (wr_ctrl && wstrb[0]) begin
      ctrl_d = wdata[5:0];
    end

    cmp0_d = wr_cmp0 ? merge_bytes(cmp0_q, wdata, wstrb) : cmp0_q;
    cmp1_d = wr_cmp1 ? merge_bytes(cmp1_q, wdata, wstrb) : cmp1_q;

    status_d = (status_q & ~w1c_mask) | hit;
  end

  // Register file state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      cmp0_q   <= '0;
      cmp1_q   <= '0;
      status_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      cmp0_q   <= cmp0_d;
      cmp1_q   <= cmp1_d;
      status_q <= status_d;
    end
  end

  // Capture the live count on every channel-0 hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_q <= '0;
    end else if (hit[0]) begin
      capture_q <= count;
    end
  end

  // ------------------------------------------------------------------------
  // Interrupt and PWM
  // ------------------------------------------------------------------------

  // Level interrupt from the registered status masked by the enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(status_q & {ctrl_q[C_IE1], ctrl_q[C_IE0]});
    end
  end

  assign irq = irq_q;

  // PWM: high while count is below CMP0; held without clk_enb, forced low when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= 1'b0;
    end else if (!ctrl_q[C_PWM_EN]) begin
      pwm_q <= 1'b0;
    end else if (clk_enb) begin
      pwm_q <= (count < cmp0_q);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_counter_cmp_irq.sv
// Directed bench for counter_cmp_irq: bus reads/writes with byte strobes,
// channel-0 match/capture/irq, hold-at-compare, oneshot, set-vs-clear
// priority, PWM sweep and count wrap-around.

module tb_counter_cmp_irq;

  logic        clk;
  logic        reset;
  logic        clk_enb;
  logic [31:0] count;
  logic        valid;
  logic        we;
  logic [2:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  match;
  logic        pwm_out;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  counter_cmp_irq #(.BITS(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_enb (clk_enb),
    .count   (count),
    .valid   (valid),
    .we      (we),
    .addr    (addr),
    .wstrb   (wstrb),
    .wdata   (wdata),
    .ready   (ready),
    .rdata   (rdata),
    .irq     (irq),
    .match   (match),
    .pwm_out (pwm_out)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Checker: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drivers: all start and end on a falling edge.
  task automatic step(input logic [31:0] c, input logic e);
    count   = c;
    clk_enb = e;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
    @(negedge clk);
    check("wr_ready", 32'(ready), 32'd1);
    valid = 1'b0;
    we    = 1'b0;
    wdata = '0;
    wstrb = '0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [2:0] a, input string tag);
    logic [31:0] e;
    valid = 1'b1;
    we    = 1'b0;
    addr  = a;
    check("rd_not_early", 32'(ready), 32'd0);
    @(negedge clk);
    check("rd_ready", 32'(ready), 32'd1);
    e = exp_q.pop_front();
    check(tag, rdata, e);
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_read(input logic [2:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    bus_read(a, tag);
  endtask

  // Stimulus
  initial begin
    int          n_m;
    logic [4:0]  en_seq;
    logic [31:0] seq4 [4];

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clk_enb  = 1'b0;
    count    = '0;
    valid    = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wstrb    = '0;
    wdata    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and empty register map
    check("rst_irq",   32'(irq),     32'd0);
    check("rst_pwm",   32'(pwm_out), 32'd0);
    check("rst_match", 32'(match),   32'd0);
    check("rst_ready", 32'(ready),   32'd0);
    check("rst_rdata", rdata,        32'd0);
    for (int a = 0; a < 8; a++) begin
      expect_read(3'(a), 32'd0, $sformatf("rst_read_%0d", a));
    end

    // Channel 0 hit, capture, irq, W1C
    bus_write(3'd1, 32'h10, 4'hF);
    bus_write(3'd0, 32'h05, 4'hF);
    step(32'h0E, 1'b1); check("ramp_0e_match", 32'(match), 32'd0);
    step(32'h0F, 1'b1); check("ramp_0f_match", 32'(match), 32'd0);
    step(32'h10, 1'b1); check("ramp_10_match", 32'(match), 32'd1);
    check("ramp_10_irq", 32'(irq), 32'd0);
    step(32'h11, 1'b1); check("ramp_11_match", 32'(match), 32'd0);
    check("ramp_11_irq", 32'(irq), 32'd1);
    step(32'h12, 1'b1);
    clk_enb = 1'b0;
    expect_read(3'd3, 32'h1,  "status_hit0");
    expect_read(3'd4, 32'h10, "capture_0x10");
    check("irq_before_clear", 32'(irq), 32'd1);
    bus_write(3'd3, 32'h1, 4'h1);
    check("irq_after_clear", 32'(irq), 32'd0);

    // Count held at CMP0 with clk_enb toggling: single hit
    en_seq = 5'b11010;
    n_m = 0;
    for (int i = 0; i < 5; i++) begin
      step(32'h10, en_seq[i]);
      n_m += int'(match[0]);
    end
    check("hold_single_pulse", 32'(n_m), 32'd1);
    clk_enb = 1'b0;
    expect_read(3'd3, 32'h1, "hold_status");
    step(32'h20, 1'b1);
    clk_enb = 1'b0;
    bus_write(3'd3, 32'h1, 4'h1);
    expect_read(3'd3, 32'h0, "hold_status_cleared");

    // Oneshot clears en0, second pass gives no hit
    bus_write(3'd0, 32'h25, 4'hF);
    step(32'h0F, 1'b1);
    step(32'h10, 1'b1); check("oneshot_match", 32'(match), 32'd1);
    step(32'h11, 1'b1);
    clk_enb = 1'b0;
    expect_read(3'd0, 32'h24, "oneshot_ctrl");
    bus_write(3'd3, 32'h1, 4'h1);
    seq4 = '{32'h0F, 32'h10, 32'h11, 32'h10};
    n_m = 0;
    for (int i = 0; i < 4; i++) begin
      step(seq4[i], 1'b1);
      n_m += int'(match[0]);
    end
    check("oneshot_no_rehit", 32'(n_m), 32'd0);
    clk_enb = 1'b0;
    expect_read(3'd3, 32'h0, "oneshot_status");

    // Byte strobes on CMP1, then hit1 against a same-cycle W1C
    bus_write(3'd2, 32'hAABBCCDD, 4'b0101);
    expect_read(3'd2, 32'h00BB00DD, "cmp1_strobe");
    bus_write(3'd0, 32'h0A, 4'hF);
    count   = 32'h00BB00DD;
    clk_enb = 1'b1;
    bus_write(3'd3, 32'h2, 4'h1);
    clk_enb = 1'b0;
    expect_read(3'd3, 32'h2, "status_set_wins");
    check("irq_hit1", 32'(irq), 32'd1);
    bus_write(3'd3, 32'h2, 4'h1);
    expect_read(3'd3, 32'h0, "status_hit1_cleared");

    // PWM sweep with CMP0 = 4, hold, forced low on disable
    bus_write(3'd1, 32'h4, 4'hF);
    bus_write(3'd0, 32'h10, 4'hF);
    for (int c = 0; c < 8; c++) begin
      step(32'(c), 1'b1);
      check($sformatf("pwm_c%0d", c), 32'(pwm_out), (c < 4) ? 32'd1 : 32'd0);
    end
    step(32'h0, 1'b1); check("pwm_c0_again", 32'(pwm_out), 32'd1);
    step(32'h7, 1'b0); check("pwm_hold",     32'(pwm_out), 32'd1);
    bus_write(3'd0, 32'h0, 4'hF);
    check("pwm_forced_low", 32'(pwm_out), 32'd0);

    // Wrap-around with CMP1 = 0
    bus_write(3'd2, 32'h0, 4'hF);
    bus_write(3'd0, 32'h02, 4'hF);
    step(32'hFFFFFFFE, 1'b1); check("wrap_fe_match", 32'(match), 32'd0);
    step(32'hFFFFFFFF, 1'b1); check("wrap_ff_match", 32'(match), 32'd0);
    step(32'h00000000, 1'b1); check("wrap_0_match",  32'(match), 32'd2);
    clk_enb = 1'b0;
    expect_read(3'd3, 32'h2, "wrap_status");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
